// File: rtl/run_leaf_loader.sv
`default_nettype none
// ============================================================================
// Module   : run_leaf_loader
// Purpose  : Unpacks 2-record beats and deals RUN_LEN-record runs round-robin
//            to 2*L leaf FIFOs, appending a zero terminator after each run.
// Revision : 1.0 - initial release
// ============================================================================
module run_leaf_loader #(
    parameter int L          = 8,
    parameter int DATA_WIDTH = 128,
    parameter int RUN_LEN    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [2*DATA_WIDTH-1:0]   i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [2*L-1:0]            i_fifo_full,
    output logic [2*L-1:0]            o_fifo_write,
    output logic [DATA_WIDTH-1:0]     o_fifo_data,
    output logic                      o_pass_done,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int c_NLEAF  = 2 * L;
    localparam int c_LEAF_W = (c_NLEAF > 1) ? $clog2(c_NLEAF) : 1;
    localparam int c_CNT_W  = $clog2(RUN_LEN);
    localparam logic [c_LEAF_W-1:0] c_LAST_LEAF = c_LEAF_W'(c_NLEAF - 1);
    localparam logic [c_CNT_W-1:0]  c_LAST_REC  = c_CNT_W'(RUN_LEN - 1);

    localparam logic [0:0] S_DATA = 1'b0;
    localparam logic [0:0] S_TERM = 1'b1;

    logic                      r_buf_valid;
    logic [2*DATA_WIDTH-1:0]   r_buf_data;
    logic                      r_half;
    logic [c_CNT_W-1:0]        r_rec_cnt;
    logic [c_LEAF_W-1:0]       r_leaf_idx;
    logic [0:0]                r_state;
    logic                      r_err;

    logic w_leaf_full;
    logic w_wr_data;
    logic w_wr_term;
    logic w_wr_any;
    logic w_accept;
    logic w_consume;
    logic w_zero_rec;

    assign w_leaf_full = i_fifo_full[r_leaf_idx];
    assign w_wr_data   = (r_state == S_DATA) && r_buf_valid && !w_leaf_full;
    assign w_wr_term   = (r_state == S_TERM) && !w_leaf_full;
    assign w_wr_any    = w_wr_data || w_wr_term;
    assign w_consume   = w_wr_data && r_half;

    // Ready while the hi record drains lets the next beat load with no bubble.
    assign o_ready     = !r_buf_valid || ((r_state == S_DATA) && r_half && !w_leaf_full);
    assign w_accept    = i_valid && o_ready;
    assign w_zero_rec  = (i_data[DATA_WIDTH-1:0] == '0) ||
                         (i_data[2*DATA_WIDTH-1:DATA_WIDTH] == '0);

    assign o_busy      = r_buf_valid || (r_state == S_TERM);
    assign o_err       = r_err;
    assign o_pass_done = w_wr_term && (r_leaf_idx == c_LAST_LEAF);

    always_comb begin
        o_fifo_data = '0;
        if (w_wr_data) begin
            o_fifo_data = r_half ? r_buf_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : r_buf_data[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        o_fifo_write = '0;
        for (int i = 0; i < c_NLEAF; i++) begin
            if (w_wr_any && (r_leaf_idx == c_LEAF_W'(i))) begin
                o_fifo_write[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
            r_half      <= 1'b0;
            r_rec_cnt   <= '0;
            r_leaf_idx  <= '0;
            r_state     <= S_DATA;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= i_data;
                if (w_zero_rec) begin
                    r_err <= 1'b1;
                end
            end else if (w_consume) begin
                r_buf_valid <= 1'b0;
            end

            if (w_wr_data) begin
                r_half <= !r_half;
                if (r_rec_cnt == c_LAST_REC) begin
                    r_rec_cnt <= '0;
                    r_state   <= S_TERM;
                end else begin
                    r_rec_cnt <= r_rec_cnt + c_CNT_W'(1);
                end
            end

            if (w_wr_term) begin
                r_leaf_idx <= (r_leaf_idx == c_LAST_LEAF) ? '0 : r_leaf_idx + c_LEAF_W'(1);
                r_state    <= S_DATA;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_leaf_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_leaf_loader
// Purpose  : Vector table on a small loader (L=1, RUN_LEN=4) plus randomized
//            and streaming runs on the full-size loader against a run model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_leaf_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic [31:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [1:0]  a_full = '0;
    logic [1:0]  a_write;
    logic [15:0] a_fdata;
    logic        a_pass, a_busy, a_err;

    // full-size instance
    logic [255:0] b_data = '0;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [15:0]  b_full = '0;
    logic [15:0]  b_write;
    logic [127:0] b_fdata;
    logic         b_pass, b_busy, b_err;

    run_leaf_loader #(.L(1), .DATA_WIDTH(16), .RUN_LEN(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready), .i_fifo_full(a_full), .o_fifo_write(a_write),
        .o_fifo_data(a_fdata), .o_pass_done(a_pass), .o_busy(a_busy), .o_err(a_err)
    );

    run_leaf_loader #(.L(8), .DATA_WIDTH(128), .RUN_LEN(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .i_fifo_full(b_full), .o_fifo_write(b_write),
        .o_fifo_data(b_fdata), .o_pass_done(b_pass), .o_busy(b_busy), .o_err(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [15:0] hi, lo;
        logic [1:0]  full;
        logic [1:0]  wr;
        logic [15:0] d;
        logic        pass, rdy, busy, err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic v, input int hi, input int lo, input logic [1:0] full,
                                input logic [1:0] wr, input int d, input logic pass,
                                input logic rdy, input logic busy, input logic err);
        vec_t t;
        t.v = v; t.hi = 16'(hi); t.lo = 16'(lo); t.full = full;
        t.wr = wr; t.d = 16'(d); t.pass = pass; t.rdy = rdy; t.busy = busy; t.err = err;
        return t;
    endfunction

    task automatic apply_a(input int i);
        @(negedge clk);
        a_valid = vt[i].v;
        a_data  = {vt[i].hi, vt[i].lo};
        a_full  = vt[i].full;
        #1;
        chk($sformatf("v%0d_write", i), 128'(a_write), 128'(vt[i].wr));
        chk($sformatf("v%0d_data", i),  128'(a_fdata), 128'(vt[i].d));
        chk($sformatf("v%0d_pass", i),  128'(a_pass),  128'(vt[i].pass));
        chk($sformatf("v%0d_ready", i), 128'(a_ready), 128'(vt[i].rdy));
        chk($sformatf("v%0d_busy", i),  128'(a_busy),  128'(vt[i].busy));
        chk($sformatf("v%0d_err", i),   128'(a_err),   128'(vt[i].err));
    endtask

    // Reference for the big instance: record queue in arrival order, and
    // write n lands on leaf (n / 17) % 16, with every 17th write a terminator.
    logic [127:0] q[$];
    int  b_n = 0;
    int  b_writes = 0;
    int  b_passes = 0;
    bit  b_acc = 1'b0;

    function automatic logic [127:0] rnd_rec();
        return {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    endfunction

    task automatic b_check();
        int leaf, pos;
        logic [127:0] exp;
        if (b_write == '0) begin
            chk("b_idle", {b_pass, b_fdata[126:0]} | 128'(b_fdata[127]), 128'h0);
        end else begin
            leaf = (b_n / 17) % 16;
            pos  = b_n % 17;
            chk("b_onehot", 128'($countones(b_write)), 128'd1);
            chk("b_leaf", 128'(b_write), 128'(16'(1) << leaf));
            chk("b_full_write", 128'(b_write & b_full), 128'h0);
            if (pos == 16) begin
                chk("b_term", b_fdata, 128'h0);
                chk("b_pass_term", 128'(b_pass), 128'(leaf == 15));
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_underrun: got write %0h with no pending record expected none", b_write);
            end else begin
                exp = q.pop_front();
                chk("b_rec", b_fdata, exp);
                chk("b_pass_rec", 128'(b_pass), 128'h0);
            end
            b_n++;
            b_writes++;
            if (b_pass) b_passes++;
        end
    endtask

    // mode 0: drain, 1: random valid/full, 2: continuous stream
    task automatic b_step(input int mode);
        @(negedge clk);
        if (b_acc) begin
            q.push_back(b_data[127:0]);
            q.push_back(b_data[255:128]);
            b_valid = 1'b0;
        end
        if (!b_valid && (mode == 2 || (mode == 1 && $urandom_range(0, 9) < 7))) begin
            b_valid = 1'b1;
            b_data  = {rnd_rec(), rnd_rec()};
        end
        b_full = '0;
        if (mode == 1) begin
            for (int k = 0; k < 16; k++) b_full[k] = ($urandom_range(0, 4) == 0);
        end
        #1;
        b_check();
        b_acc = b_valid && b_ready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; b_full = '0; a_full = '0;
        b_acc = 1'b0; b_n = 0; q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ws, ps, guard;

        // basic distribution
        vt.push_back(mk(1, 2, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 4, 3, 2'b00, 2'b01, 1, 0, 0, 1, 0));
        vt.push_back(mk(1, 4, 3, 2'b00, 2'b01, 2, 0, 1, 1, 0));
        vt.push_back(mk(1, 6, 5, 2'b00, 2'b01, 3, 0, 0, 1, 0));
        vt.push_back(mk(1, 6, 5, 2'b00, 2'b01, 4, 0, 1, 1, 0));
        vt.push_back(mk(1, 8, 7, 2'b00, 2'b01, 0, 0, 0, 1, 0));
        vt.push_back(mk(1, 8, 7, 2'b00, 2'b10, 5, 0, 0, 1, 0));
        vt.push_back(mk(1, 8, 7, 2'b00, 2'b10, 6, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b10, 7, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b10, 8, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        // backpressure on leaf 0 after record 2
        vt.push_back(mk(1, 12, 11, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 14, 13, 2'b00, 2'b01, 11, 0, 0, 1, 0));
        vt.push_back(mk(1, 14, 13, 2'b00, 2'b01, 12, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 13, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 14, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 1, 0));
        // terminator stall on leaf 1
        vt.push_back(mk(1, 22, 21, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 24, 23, 2'b00, 2'b10, 21, 0, 0, 1, 0));
        vt.push_back(mk(1, 24, 23, 2'b00, 2'b10, 22, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b10, 23, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b10, 24, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        // zero record: forwarded, flags sticky error; leaf 0 confirms wrap
        vt.push_back(mk(1, 5, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 5, 0, 1, 1, 1));
        vt.push_back(mk(1, 7, 6, 2'b00, 2'b00, 0, 0, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 6, 0, 0, 1, 1));
        // after mid-stream reset: fresh run on leaf 0
        vt.push_back(mk(1, 32, 31, 2'b00, 2'b00, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 34, 33, 2'b00, 2'b01, 31, 0, 0, 1, 0));
        vt.push_back(mk(1, 34, 33, 2'b00, 2'b01, 32, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 33, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 34, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0));

        // reset state
        @(negedge clk);
        #1;
        chk("rst_write", 128'(a_write), 128'h0);
        chk("rst_ready", 128'(a_ready), 128'h1);
        chk("rst_busy",  128'(a_busy),  128'h0);
        chk("rst_err",   128'(a_err),   128'h0);
        chk("rst_pass",  128'(a_pass),  128'h0);
        chk("rst_b_ready", 128'(b_ready), 128'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 35; i++) apply_a(i);

        // asynchronous reset while a beat is half written
        #2;
        rst_n = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("async_rst_write", 128'(a_write), 128'h0);
        chk("async_rst_ready", 128'(a_ready), 128'h1);
        chk("async_rst_busy",  128'(a_busy),  128'h0);
        chk("async_rst_err",   128'(a_err),   128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 35; i < vt.size(); i++) apply_a(i);

        // randomized traffic with backpressure on the full-size loader
        do_reset();
        repeat (800) b_step(1);
        repeat (60) b_step(0);
        chk("b_drain_empty", 128'(q.size()), 128'h0);
        chk("b_err_clear", 128'(b_err), 128'h0);
        chk("b_idle_busy", 128'(b_busy), 128'h0);

        // throughput: 272 writes and one pass pulse per 272 cycles
        do_reset();
        guard = 0;
        while (b_writes == 0 || guard == 0) begin
            if (guard == 0) b_writes = 0;
            b_step(2);
            guard++;
            if (guard > 10) break;
        end
        if (b_writes == 0) begin
            checks++;
            errors++;
            $display("FAIL tput_start: got no write within 10 cycles expected a write");
        end else begin
            ws = b_writes - 1;
            ps = b_passes;
            repeat (271) b_step(2);
            chk("tput_writes_1", 128'(b_writes - ws), 128'd272);
            chk("tput_pass_1", 128'(b_passes - ps), 128'd1);
            ws = b_writes;
            ps = b_passes;
            repeat (272) b_step(2);
            chk("tput_writes_2", 128'(b_writes - ws), 128'd272);
            chk("tput_pass_2", 128'(b_passes - ps), 128'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
